// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle shared by the packet-processing stages.
// The sink side drives ready; the src side drives everything else.
interface avalon_st_if #(
    parameter int DWIDTH        = 64,
    parameter int CHANNEL_WIDTH = 1
) ();
    localparam int EW = (DWIDTH > 8) ? $clog2(DWIDTH / 8) : 1;

    logic [DWIDTH-1:0]        data;
    logic                     valid;
    logic                     ready;
    logic                     startofpacket;
    logic                     endofpacket;
    logic [EW-1:0]            empty;
    logic [CHANNEL_WIDTH-1:0] channel;

    modport sink (
        input  data, valid, startofpacket, endofpacket, empty, channel,
        output ready
    );

    modport src (
        output data, valid, startofpacket, endofpacket, empty, channel,
        input  ready
    );
endinterface

// File: rtl/avalon_st_pkt_buffer.sv
// Store-and-forward packet buffer: packets are released only once complete;
// overflowing or malformed packets are discarded whole and counted.
module avalon_st_pkt_buffer #(
    parameter int DWIDTH        = 64,
    parameter int CHANNEL_WIDTH = 1,
    parameter int DEPTH         = 256
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    avalon_st_if.sink snk_if,
    avalon_st_if.src  src_if,
    output logic [15:0] drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = (DWIDTH > 8) ? $clog2(DWIDTH / 8) : 1;

    typedef logic [AW:0] ptr_t;
    localparam ptr_t FULL = ptr_t'(DEPTH);

    typedef struct packed {
        logic [DWIDTH-1:0]        data;
        logic                     sop;
        logic                     eop;
        logic [EW-1:0]            empty;
        logic [CHANNEL_WIDTH-1:0] channel;
    } word_t;

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    word_t  mem [DEPTH];
    word_t  in_word;
    word_t  s1_word;
    word_t  out_word;
    ptr_t   wr_ptr;
    ptr_t   commit_ptr;
    ptr_t   rd_ptr;
    state_t state;
    logic   ready_q;
    logic   s1_vld;
    logic   out_vld;
    logic   [15:0] drop_cnt;

    logic   beat;
    logic   we;
    ptr_t   waddr;
    ptr_t   base;
    ptr_t   used_base;
    ptr_t   used_wr;
    ptr_t   nxt_wr;
    ptr_t   nxt_commit;
    state_t nxt_state;
    logic   [1:0] inc;
    logic   [16:0] cnt_sum;
    logic   out_take;
    logic   s1_free;
    logic   rd_en;

    assign in_word = {snk_if.data, snk_if.startofpacket,
                      snk_if.endofpacket, snk_if.empty, snk_if.channel};
    assign beat    = snk_if.valid && ready_q;
    assign used_wr = wr_ptr - rd_ptr;

    always_comb begin
        we         = 1'b0;
        waddr      = wr_ptr;
        nxt_wr     = wr_ptr;
        nxt_commit = commit_ptr;
        nxt_state  = state;
        inc        = 2'd0;
        base       = wr_ptr;
        used_base  = used_wr;
        if (beat && in_word.sop) begin
            // A new sop while a packet is open abandons the open one first
            if (state == WRITE) begin
                base      = commit_ptr;
                used_base = commit_ptr - rd_ptr;
                inc       = 2'd1;
            end
            if (used_base != FULL) begin
                we     = 1'b1;
                waddr  = base;
                nxt_wr = base + ptr_t'(1);
                if (in_word.eop) begin
                    nxt_commit = base + ptr_t'(1);
                    nxt_state  = IDLE;
                end else begin
                    nxt_state = WRITE;
                end
            end else begin
                nxt_wr    = base;
                inc       = inc + 2'd1;
                nxt_state = in_word.eop ? IDLE : DROP;
            end
        end else if (beat) begin
            case (state)
                WRITE: begin
                    if (used_wr != FULL) begin
                        we     = 1'b1;
                        nxt_wr = wr_ptr + ptr_t'(1);
                        if (in_word.eop) begin
                            nxt_commit = wr_ptr + ptr_t'(1);
                            nxt_state  = IDLE;
                        end
                    end else begin
                        nxt_wr    = commit_ptr;
                        inc       = 2'd1;
                        nxt_state = in_word.eop ? IDLE : DROP;
                    end
                end
                DROP: begin
                    if (in_word.eop) nxt_state = IDLE;
                end
                default: ;
            endcase
        end
    end

    assign cnt_sum = {1'b0, drop_cnt} + 17'(inc);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ready_q    <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            state      <= IDLE;
            drop_cnt   <= '0;
        end else begin
            ready_q    <= 1'b1;
            wr_ptr     <= nxt_wr;
            commit_ptr <= nxt_commit;
            state      <= nxt_state;
            drop_cnt   <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    // Two-stage read: synchronous RAM read into s1, then the output register
    assign out_take = !out_vld || src_if.ready;
    assign s1_free  = !s1_vld || out_take;
    assign rd_en    = (rd_ptr != commit_ptr) && s1_free;

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr[AW-1:0]] <= in_word;
        if (rd_en) s1_word <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr   <= '0;
            s1_vld   <= 1'b0;
            out_vld  <= 1'b0;
            out_word <= '0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
            s1_vld <= rd_en || (s1_vld && !out_take);
            if (out_take) begin
                out_vld <= s1_vld;
                if (s1_vld) out_word <= s1_word;
            end
        end
    end

    assign snk_if.ready         = ready_q;
    assign src_if.valid         = out_vld;
    assign src_if.data          = out_word.data;
    assign src_if.startofpacket = out_word.sop;
    assign src_if.endofpacket   = out_word.eop;
    assign src_if.empty         = out_word.empty;
    assign src_if.channel       = out_word.channel;
    assign drop_cnt_o           = drop_cnt;
endmodule

// File: tb/tb_avalon_st_pkt_buffer.sv
// Directed bench for avalon_st_pkt_buffer: cycle table for latency and
// backpressure, then packet-level sequences for drop and reset cases.
module tb_avalon_st_pkt_buffer;
    localparam int DW = 64;
    localparam int CW = 1;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] drop_cnt;
    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    avalon_st_if #(.DWIDTH(DW), .CHANNEL_WIDTH(CW)) snk ();
    avalon_st_if #(.DWIDTH(DW), .CHANNEL_WIDTH(CW)) src ();

    avalon_st_pkt_buffer #(.DWIDTH(DW), .CHANNEL_WIDTH(CW), .DEPTH(D)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .snk_if(snk),
        .src_if(src),
        .drop_cnt_o(drop_cnt)
    );

    typedef struct {
        logic        v, sop, eop;
        logic [63:0] d;
        logic [2:0]  emp;
        logic        ch;
        logic        rdy;
        logic        ev, esop, eeop;
        logic [63:0] ed;
        logic [2:0]  eemp;
        logic        ech;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        sop, eop;
        int          c;
    } obs_t;

    obs_t got[$];
    vec_t tbl[18];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && src.valid && src.ready)
            got.push_back('{src.data, src.startofpacket, src.endofpacket, cyc});
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic v, logic sop, logic eop, logic [63:0] d,
                                logic [2:0] emp, logic ch, logic rdy,
                                logic ev, logic esop, logic eeop,
                                logic [63:0] ed, logic [2:0] eemp, logic ech);
        vec_t r;
        r = '{v, sop, eop, d, emp, ch, rdy, ev, esop, eeop, ed, eemp, ech};
        return r;
    endfunction

    task automatic drive_idle();
        snk.valid = 1'b0;
        snk.startofpacket = 1'b0;
        snk.endofpacket = 1'b0;
        snk.data = '0;
        snk.empty = '0;
        snk.channel = '0;
    endtask

    task automatic send(input logic sop, input logic eop, input logic [63:0] d);
        snk.valid = 1'b1;
        snk.startofpacket = sop;
        snk.endofpacket = eop;
        snk.data = d;
        snk.empty = 3'd0;
        snk.channel = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [63:0] b, input int n);
        for (int i = 0; i < n; i++)
            send(i == 0, i == n - 1, b + 64'(i));
    endtask

    // Expect n words b, b+1, ... split into packets of plen words each
    task automatic check_seq(input string name, input logic [63:0] b,
                             input int n, input int plen, input bit gapless);
        check({name, "_count"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            check($sformatf("%s_d%0d", name, i), got[i].d, b + 64'(i));
            check($sformatf("%s_sop%0d", name, i), 64'(got[i].sop),
                  64'(i % plen == 0));
            check($sformatf("%s_eop%0d", name, i), 64'(got[i].eop),
                  64'(i % plen == plen - 1));
            if (gapless && i > 0)
                check($sformatf("%s_gap%0d", name, i), 64'(got[i].c),
                      64'(got[i-1].c + 1));
        end
    endtask

    initial begin
        drive_idle();
        src.ready = 1'b1;

        tbl[0]  = mk(1,1,1,64'hA5,3,1, 1, 0,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0, 1, 0,0,0,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,0, 1, 0,0,0,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,0, 1, 1,1,1,64'hA5,3,1);
        tbl[4]  = mk(0,0,0,0,0,0, 1, 0,0,0,0,0,0);
        tbl[5]  = mk(1,1,0,1,0,0, 0, 0,0,0,0,0,0);
        tbl[6]  = mk(1,0,0,2,0,0, 0, 0,0,0,0,0,0);
        tbl[7]  = mk(1,0,0,3,0,0, 0, 0,0,0,0,0,0);
        tbl[8]  = mk(1,0,1,4,0,0, 0, 0,0,0,0,0,0);
        tbl[9]  = mk(0,0,0,0,0,0, 0, 0,0,0,0,0,0);
        tbl[10] = mk(0,0,0,0,0,0, 0, 0,0,0,0,0,0);
        tbl[11] = mk(0,0,0,0,0,0, 0, 1,1,0,1,0,0);
        tbl[12] = mk(0,0,0,0,0,0, 0, 1,1,0,1,0,0);
        tbl[13] = mk(0,0,0,0,0,0, 1, 1,1,0,1,0,0);
        tbl[14] = mk(0,0,0,0,0,0, 1, 1,0,0,2,0,0);
        tbl[15] = mk(0,0,0,0,0,0, 1, 1,0,0,3,0,0);
        tbl[16] = mk(0,0,0,0,0,0, 1, 1,0,1,4,0,0);
        tbl[17] = mk(0,0,0,0,0,0, 1, 0,0,0,0,0,0);

        #2;
        check("rst_snk_ready", 64'(snk.ready), 64'd0);
        check("rst_valid", 64'(src.valid), 64'd0);
        check("rst_sop_eop", {62'd0, src.startofpacket, src.endofpacket}, 64'd0);
        check("rst_data", src.data, 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        #10 rst_n = 1'b1;
        #1 check("ready_before_edge", 64'(snk.ready), 64'd0);
        @(posedge clk);
        #1 check("ready_after_edge", 64'(snk.ready), 64'd1);

        for (int i = 0; i < 18; i++) begin
            snk.valid = tbl[i].v;
            snk.startofpacket = tbl[i].sop;
            snk.endofpacket = tbl[i].eop;
            snk.data = tbl[i].d;
            snk.empty = tbl[i].emp;
            snk.channel = tbl[i].ch;
            src.ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d_valid", i), 64'(src.valid), 64'(tbl[i].ev));
            if (tbl[i].ev)
                check($sformatf("row%0d_word", i),
                      {src.data[57:0], src.startofpacket, src.endofpacket,
                       src.empty, src.channel},
                      {tbl[i].ed[57:0], tbl[i].esop, tbl[i].eeop,
                       tbl[i].eemp, tbl[i].ech});
            @(posedge clk);
            #1;
        end
        check("tbl_drop", 64'(drop_cnt), 64'd0);

        got.delete();
        send_pkt(64'h20, 9);
        send_pkt(64'h30, 8);
        idle(16);
        check_seq("ovf", 64'h30, 8, 8, 1'b1);
        check("ovf_drop", 64'(drop_cnt), 64'd1);

        got.delete();
        send(1'b1, 1'b0, 64'h40);
        send(1'b0, 1'b0, 64'h41);
        send(1'b0, 1'b0, 64'h42);
        send_pkt(64'h10, 2);
        idle(8);
        check_seq("malf", 64'h10, 2, 2, 1'b1);
        check("malf_drop", 64'(drop_cnt), 64'd2);

        got.delete();
        send(1'b0, 1'b1, 64'h50);
        send(1'b1, 1'b1, 64'h51);
        idle(8);
        check_seq("stray", 64'h51, 1, 1, 1'b1);
        check("stray_drop", 64'(drop_cnt), 64'd2);

        got.delete();
        send_pkt(64'h60, 3);
        send_pkt(64'h63, 3);
        send_pkt(64'h66, 3);
        idle(12);
        check_seq("b2b", 64'h60, 9, 3, 1'b1);

        got.delete();
        send_pkt(64'h80, 3);
        send(1'b1, 1'b0, 64'h83);
        send(1'b0, 1'b0, 64'h84);
        check("pre_rst_valid", 64'(src.valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(src.valid), 64'd0);
        check("arst_data", src.data, 64'd0);
        check("arst_side", {59'd0, src.startofpacket, src.endofpacket,
                            src.empty}, 64'd0);
        check("arst_ready", 64'(snk.ready), 64'd0);
        check("arst_drop", 64'(drop_cnt), 64'd0);
        drive_idle();
        got.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1'b1, 1'b1, 64'h77);
        idle(6);
        check_seq("post_rst", 64'h77, 1, 1, 1'b1);
        check("post_rst_drop", 64'(drop_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
